bullet_bill_controller: RTL and testbench

- Owns the three Bullet Bill slots (color, column, row) consumed by the graphics generator.
- Spawns a bullet in front of Blockieee on a fire request and advances all bullets one cell right per move tick.
- Resolves collisions against the DDaver grid and reports hits to the enemy-state owner.
- Sits directly upstream of the graphics generator. Its bullet outputs drive that stage's bulletBillColor/XLoc/YLoc inputs unmodified.

---
 rtl/bullet_bill_controller.sv | 260 ++++++++++++++++++++++++++
 tb/tb_bullet_bill_controller.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_bill_controller.sv
// ---------------------------------------------------------------------------
// bullet_bill_controller
//
// Owns the three Bullet Bill slots that feed the graphics generator. A fire
// request spawns a bullet in front of Blockieee; each move tick advances all
// live bullets one column right and then sweeps the slots one per cycle,
// checking each against the DDaver grid and reporting hits.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   move_tick           single-cycle advance strobe (ignored while busy)
//   fire_req/fire_ack   fire handshake; ack is a one-cycle pulse
//   fire_color          RGB444 color of the bullet to fire
//   blockieee           Blockieee row (spawn row)
//   ddavers             DDaver color grid [row 0..4][col 0..5], 0 = empty
//   bulletBillColor/XLoc/YLoc  registered slot state (color 0 = free slot)
//   hit_valid/hit_kill  one-cycle hit report; kill = colors matched
//   hit_row/hit_col     DDaver grid index of the reported hit
//   busy                high while a collision sweep is in progress
// ---------------------------------------------------------------------------
module bullet_bill_controller #(
    parameter int NUM_BULLETS = 3,
    parameter int SPAWN_COL   = 2,
    parameter int LAST_COL    = 15,
    parameter int MAX_ROW     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move_tick,
    input  logic        fire_req,
    output logic        fire_ack,
    input  logic [11:0] fire_color,
    input  logic [3:0]  blockieee,
    input  logic [11:0] ddavers [0:4][0:5],
    output logic [11:0] bulletBillColor [0:NUM_BULLETS-1],
    output logic [3:0]  bulletBillXLoc  [0:NUM_BULLETS-1],
    output logic [3:0]  bulletBillYLoc  [0:NUM_BULLETS-1],
    output logic        hit_valid,
    output logic        hit_kill,
    output logic [2:0]  hit_row,
    output logic [2:0]  hit_col,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK0 = 2'd1,
        CHECK1 = 2'd2,
        CHECK2 = 2'd3
    } state_e;

    state_e      state_reg, state_next;

    logic [11:0] color_reg [0:NUM_BULLETS-1];
    logic [11:0] color_next[0:NUM_BULLETS-1];
    logic [3:0]  x_reg     [0:NUM_BULLETS-1];
    logic [3:0]  x_next    [0:NUM_BULLETS-1];
    logic [3:0]  y_reg     [0:NUM_BULLETS-1];
    logic [3:0]  y_next    [0:NUM_BULLETS-1];

    // Cells killed earlier in the current sweep; at most two kills can
    // precede the last slot's check.
    logic [1:0]  kill_v_reg, kill_v_next;
    logic [2:0]  kill_row_reg [0:1];
    logic [2:0]  kill_row_next[0:1];
    logic [2:0]  kill_col_reg [0:1];
    logic [2:0]  kill_col_next[0:1];

    logic        fire_ack_reg, fire_ack_next;
    logic        hit_valid_reg, hit_valid_next;
    logic        hit_kill_reg, hit_kill_next;
    logic [2:0]  hit_row_reg, hit_row_next;
    logic [2:0]  hit_col_reg, hit_col_next;

    // Per-slot grid decode
    logic [NUM_BULLETS-1:0] slot_cell;
    logic [2:0]  slot_row [0:NUM_BULLETS-1];
    logic [2:0]  slot_col [0:NUM_BULLETS-1];
    logic [1:0]  kill_match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
            // DDaver cells sit on odd rows and even columns from column 4,
            // rows 1..9; anything else (incl. the spawn column) is open air.
            assign slot_cell[gi] = y_reg[gi][0] && !x_reg[gi][0] &&
                                   (x_reg[gi] >= 4'd4) && (y_reg[gi] <= 4'd9);
            assign slot_row[gi]  = y_reg[gi][3:1];
            assign slot_col[gi]  = x_reg[gi][3:1] - 3'd2;

            assign bulletBillColor[gi] = color_reg[gi];
            assign bulletBillXLoc[gi]  = x_reg[gi];
            assign bulletBillYLoc[gi]  = y_reg[gi];
        end
    endgenerate

    // Slot under test in the current CHECK state
    logic [1:0]  sel_idx;
    logic [2:0]  sel_row, sel_col;
    logic [11:0] cell_color;
    logic        sel_hit, sel_kill;

    assign sel_idx = (state_reg == IDLE) ? 2'd0 : 2'(state_reg - 2'd1);
    assign sel_row = slot_row[sel_idx];
    assign sel_col = slot_col[sel_idx];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_kill
            assign kill_match[gi] = kill_v_reg[gi] &&
                                    (kill_row_reg[gi] == sel_row) &&
                                    (kill_col_reg[gi] == sel_col);
        end
    endgenerate

    // Explicit mux keeps the grid read in range even for non-DDaver cells
    always_comb begin
        cell_color = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (sel_row == 3'(r) && sel_col == 3'(c)) begin
                    cell_color = ddavers[r][c];
                end
            end
        end
    end

    assign sel_hit  = (state_reg != IDLE) && (color_reg[sel_idx] != '0) &&
                      slot_cell[sel_idx] && (cell_color != '0) && (kill_match == 2'b00);
    assign sel_kill = (cell_color == color_reg[sel_idx]);

    // Lowest-index free slot
    logic        free_found;
    logic [1:0]  free_idx;

    always_comb begin
        free_found = 1'b0;
        free_idx   = 2'd0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (color_reg[i] == '0) begin
                free_found = 1'b1;
                free_idx   = 2'(i);
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_next     = state_reg;
        color_next     = color_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        kill_v_next    = kill_v_reg;
        kill_row_next  = kill_row_reg;
        kill_col_next  = kill_col_reg;
        fire_ack_next  = 1'b0;
        hit_valid_next = 1'b0;
        hit_kill_next  = 1'b0;
        hit_row_next   = hit_row_reg;
        hit_col_next   = hit_col_reg;

        case (state_reg)
            IDLE: begin
                if (move_tick) begin
                    for (int i = 0; i < NUM_BULLETS; i++) begin
                        if (color_reg[i] != '0) begin
                            if (x_reg[i] == 4'(LAST_COL)) begin
                                color_next[i] = '0;  // flew off-grid silently
                            end else begin
                                x_next[i] = x_reg[i] + 4'd1;
                            end
                        end
                    end
                    kill_v_next = 2'b00;
                    state_next  = CHECK0;
                end else if (fire_req) begin
                    if (fire_color == '0 || blockieee > 4'(MAX_ROW)) begin
                        // Unfireable request is consumed without a spawn
                        fire_ack_next = 1'b1;
                    end else if (free_found) begin
                        color_next[free_idx] = fire_color;
                        x_next[free_idx]     = 4'(SPAWN_COL);
                        y_next[free_idx]     = blockieee;
                        fire_ack_next        = 1'b1;
                    end
                end
            end
            default: begin
                if (sel_hit) begin
                    hit_valid_next       = 1'b1;
                    hit_kill_next        = sel_kill;
                    hit_row_next         = sel_row;
                    hit_col_next         = sel_col;
                    color_next[sel_idx]  = '0;
                    x_next[sel_idx]      = '0;
                    y_next[sel_idx]      = '0;
                    if (sel_kill) begin
                        if (!kill_v_reg[0]) begin
                            kill_v_next[0]   = 1'b1;
                            kill_row_next[0] = sel_row;
                            kill_col_next[0] = sel_col;
                        end else begin
                            kill_v_next[1]   = 1'b1;
                            kill_row_next[1] = sel_row;
                            kill_col_next[1] = sel_col;
                        end
                    end
                end
                state_next = (state_reg == CHECK2) ? IDLE : state_e'(state_reg + 2'd1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                color_reg[i] <= '0;
                x_reg[i]     <= '0;
                y_reg[i]     <= '0;
            end
            for (int k = 0; k < 2; k++) begin
                kill_row_reg[k] <= '0;
                kill_col_reg[k] <= '0;
            end
            kill_v_reg    <= 2'b00;
            fire_ack_reg  <= 1'b0;
            hit_valid_reg <= 1'b0;
            hit_kill_reg  <= 1'b0;
            hit_row_reg   <= '0;
            hit_col_reg   <= '0;
        end else begin
            color_reg     <= color_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            kill_v_reg    <= kill_v_next;
            kill_row_reg  <= kill_row_next;
            kill_col_reg  <= kill_col_next;
            fire_ack_reg  <= fire_ack_next;
            hit_valid_reg <= hit_valid_next;
            hit_kill_reg  <= hit_kill_next;
            hit_row_reg   <= hit_row_next;
            hit_col_reg   <= hit_col_next;
        end
    end

    assign fire_ack  = fire_ack_reg;
    assign hit_valid = hit_valid_reg;
    assign hit_kill  = hit_kill_reg;
    assign hit_row   = hit_row_reg;
    assign hit_col   = hit_col_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_bullet_bill_controller.sv
// ---------------------------------------------------------------------------
// tb_bullet_bill_controller
//
// Directed bench for bullet_bill_controller: reset, fire handshake, move and
// off-grid exit, hit/kill reporting, full-slot back-pressure, kill memory
// within a sweep, tick-while-busy and reset in the middle of a sweep.
// ---------------------------------------------------------------------------
module tb_bullet_bill_controller;

    logic        clk;
    logic        rst_n;
    logic        move_tick;
    logic        fire_req;
    logic        fire_ack;
    logic [11:0] fire_color;
    logic [3:0]  blockieee;
    logic [11:0] ddavers [0:4][0:5];
    logic [11:0] bulletBillColor [0:2];
    logic [3:0]  bulletBillXLoc  [0:2];
    logic [3:0]  bulletBillYLoc  [0:2];
    logic        hit_valid;
    logic        hit_kill;
    logic [2:0]  hit_row;
    logic [2:0]  hit_col;
    logic        busy;

    int total = 0;
    int bad   = 0;

    bullet_bill_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .move_tick       (move_tick),
        .fire_req        (fire_req),
        .fire_ack        (fire_ack),
        .fire_color      (fire_color),
        .blockieee       (blockieee),
        .ddavers         (ddavers),
        .bulletBillColor (bulletBillColor),
        .bulletBillXLoc  (bulletBillXLoc),
        .bulletBillYLoc  (bulletBillYLoc),
        .hit_valid       (hit_valid),
        .hit_kill        (hit_kill),
        .hit_row         (hit_row),
        .hit_col         (hit_col),
        .busy            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_grid();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 6; c++)
                ddavers[r][c] = 12'h000;
    endtask

    // Fire and wait (bounded) for the ack; cyc = edges until ack, 8 = none
    task automatic fire(input logic [11:0] col, input logic [3:0] row, output int cyc);
        fire_color = col;
        blockieee  = row;
        fire_req   = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!fire_ack && cyc < 8);
        fire_req = 1'b0;
        $display("fire color=%h row=%0d ack_after=%0d", col, row, cyc);
    endtask

    // One tick plus the three check edges; counts hit_valid pulses seen
    task automatic do_sweep(output int hits);
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        hits = int'(hit_valid);
        repeat (3) begin
            step();
            hits += int'(hit_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (fire_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", fire_ack); end
        total++; if ({hit_valid, hit_kill, hit_row, hit_col} !== 8'h00) begin bad++;
            $display("FAIL reset_hit got=%b%b %0d %0d want=00 0 0", hit_valid, hit_kill, hit_row, hit_col); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bulletBillColor[i] !== 12'h0 || bulletBillXLoc[i] !== 4'h0 || bulletBillYLoc[i] !== 4'h0) begin
                bad++;
                $display("FAIL reset_slot%0d got=%h/%0d/%0d want=000/0/0", i,
                         bulletBillColor[i], bulletBillXLoc[i], bulletBillYLoc[i]);
            end
        end
        rst_n = 1'b1;
        step();
        $display("reset released");
    endtask

    task automatic test_fire();
        int cyc;
        fire(12'hF00, 4'd3, cyc);
        total++; if (cyc !== 1) begin bad++; $display("FAIL fire_latency got=%0d want=1", cyc); end
        total++; if (bulletBillColor[0] !== 12'hF00 || bulletBillXLoc[0] !== 4'd2 || bulletBillYLoc[0] !== 4'd3) begin
            bad++; $display("FAIL fire_slot0 got=%h/%0d/%0d want=F00/2/3",
                            bulletBillColor[0], bulletBillXLoc[0], bulletBillYLoc[0]); end
        total++; if (bulletBillColor[1] !== 12'h0 || bulletBillColor[2] !== 12'h0) begin
            bad++; $display("FAIL fire_others got=%h,%h want=000,000", bulletBillColor[1], bulletBillColor[2]); end
        step();
        total++; if (fire_ack !== 1'b0) begin bad++; $display("FAIL fire_ack_pulse got=%b want=0", fire_ack); end
        // Unfireable requests are acked but spawn nothing
        fire(12'h000, 4'd4, cyc);
        total++; if (cyc !== 1 || bulletBillColor[1] !== 12'h0) begin bad++;
            $display("FAIL fire_zero_color got=ack%0d/%h want=ack1/000", cyc, bulletBillColor[1]); end
        fire(12'h0F0, 4'd11, cyc);
        total++; if (cyc !== 1 || bulletBillColor[1] !== 12'h0) begin bad++;
            $display("FAIL fire_bad_row got=ack%0d/%h want=ack1/000", cyc, bulletBillColor[1]); end
    endtask

    task automatic test_hit_kill();
        int h;
        do_sweep(h);
        total++; if (h !== 0 || bulletBillXLoc[0] !== 4'd3) begin bad++;
            $display("FAIL pre_move got=hits%0d/x%0d want=hits0/x3", h, bulletBillXLoc[0]); end
        ddavers[1][0] = 12'hF00;
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        total++; if (bulletBillXLoc[0] !== 4'd4 || busy !== 1'b1 || hit_valid !== 1'b0) begin bad++;
            $display("FAIL kill_e0 got=x%0d busy%b hv%b want=x4 busy1 hv0", bulletBillXLoc[0], busy, hit_valid); end
        step();
        total++; if (hit_valid !== 1'b1 || hit_kill !== 1'b1 || hit_row !== 3'd1 || hit_col !== 3'd0) begin bad++;
            $display("FAIL kill_e1 got=hv%b k%b r%0d c%0d want=hv1 k1 r1 c0", hit_valid, hit_kill, hit_row, hit_col); end
        total++; if (bulletBillColor[0] !== 12'h0 || bulletBillXLoc[0] !== 4'd0 || bulletBillYLoc[0] !== 4'd0) begin bad++;
            $display("FAIL kill_clear got=%h/%0d/%0d want=000/0/0",
                     bulletBillColor[0], bulletBillXLoc[0], bulletBillYLoc[0]); end
        step();
        total++; if (hit_valid !== 1'b0 || busy !== 1'b1) begin bad++;
            $display("FAIL kill_e2 got=hv%b busy%b want=hv0 busy1", hit_valid, busy); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_e3_busy got=%b want=0", busy); end
        $display("kill sweep done");
    endtask

    task automatic test_hit_nokill();
        int cyc, h;
        clear_grid();
        fire(12'hF00, 4'd3, cyc);
        do_sweep(h);
        total++; if (cyc !== 1 || h !== 0 || bulletBillXLoc[0] !== 4'd3) begin bad++;
            $display("FAIL nokill_setup got=ack%0d hits%0d x%0d want=ack1 hits0 x3", cyc, h, bulletBillXLoc[0]); end
        ddavers[1][0] = 12'h0F0;
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        step();
        total++; if (hit_valid !== 1'b1 || hit_kill !== 1'b0 || hit_row !== 3'd1 || hit_col !== 3'd0) begin bad++;
            $display("FAIL nokill_e1 got=hv%b k%b r%0d c%0d want=hv1 k0 r1 c0", hit_valid, hit_kill, hit_row, hit_col); end
        total++; if (bulletBillColor[0] !== 12'h0) begin bad++;
            $display("FAIL nokill_clear got=%h want=000", bulletBillColor[0]); end
        step();
        step();
        clear_grid();
        $display("no-kill sweep done");
    endtask

    task automatic test_exit();
        int cyc, h, acc;
        fire(12'h0FF, 4'd5, cyc);
        acc = 0;
        repeat (13) begin
            do_sweep(h);
            acc += h;
        end
        total++; if (cyc !== 1 || acc !== 0 || bulletBillXLoc[0] !== 4'd15) begin bad++;
            $display("FAIL exit_setup got=ack%0d hits%0d x%0d want=ack1 hits0 x15", cyc, acc, bulletBillXLoc[0]); end
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        total++; if (bulletBillColor[0] !== 12'h0) begin bad++;
            $display("FAIL exit_color got=%h want=000", bulletBillColor[0]); end
        h = 0;
        repeat (3) begin step(); h += int'(hit_valid); end
        total++; if (h !== 0 || busy !== 1'b0) begin bad++;
            $display("FAIL exit_sweep got=hits%0d busy%b want=hits0 busy0", h, busy); end
        $display("exit sweep done");
    endtask

    task automatic test_full();
        int cyc, h, acc, acks;
        fire(12'h00F, 4'd1, cyc);      // slot0, will be hit at X=6,Y=1
        fire(12'h0F0, 4'd2, cyc);      // slot1, even row, never hits
        ddavers[0][1] = 12'h0AA;
        acc = 0;
        repeat (4) begin do_sweep(h); acc += h; end
        total++; if (acc !== 1 || bulletBillColor[0] !== 12'h0) begin bad++;
            $display("FAIL full_clear0 got=hits%0d c%h want=hits1 c000", acc, bulletBillColor[0]); end
        clear_grid();
        acc = 0;
        repeat (9) begin do_sweep(h); acc += h; end
        total++; if (acc !== 0 || bulletBillXLoc[1] !== 4'd15) begin bad++;
            $display("FAIL full_slot1_x got=hits%0d x%0d want=hits0 x15", acc, bulletBillXLoc[1]); end
        fire(12'h111, 4'd4, cyc);      // slot0
        fire(12'h222, 4'd6, cyc);      // slot2
        total++; if (bulletBillColor[0] !== 12'h111 || bulletBillColor[2] !== 12'h222) begin bad++;
            $display("FAIL full_fill got=%h,%h want=111,222", bulletBillColor[0], bulletBillColor[2]); end
        // All slots busy: the held request must wait
        fire_color = 12'h333;
        blockieee  = 4'd8;
        fire_req   = 1'b1;
        acks = 0;
        repeat (3) begin step(); acks += int'(fire_ack); end
        total++; if (acks !== 0) begin bad++; $display("FAIL full_no_ack got=%0d want=0", acks); end
        move_tick = 1'b1;              // tick wins over the pending fire
        step();
        move_tick = 1'b0;
        total++; if (bulletBillColor[1] !== 12'h0 || fire_ack !== 1'b0) begin bad++;
            $display("FAIL full_exit got=c%h ack%b want=c000 ack0", bulletBillColor[1], fire_ack); end
        cyc = 0;
        do begin step(); cyc++; end while (!fire_ack && cyc < 10);
        fire_req = 1'b0;
        $display("held fire acked after %0d edges", cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL full_ack_latency got=%0d want=4", cyc); end
        total++; if (bulletBillColor[1] !== 12'h333 || bulletBillXLoc[1] !== 4'd2 || bulletBillYLoc[1] !== 4'd8) begin bad++;
            $display("FAIL full_respawn got=%h/%0d/%0d want=333/2/8",
                     bulletBillColor[1], bulletBillXLoc[1], bulletBillYLoc[1]); end
        total++; if (bulletBillColor[0] !== 12'h111 || bulletBillXLoc[0] !== 4'd3) begin bad++;
            $display("FAIL full_slot0 got=%h/%0d want=111/3", bulletBillColor[0], bulletBillXLoc[0]); end
    endtask

    task automatic test_back_to_back();
        int cyc, h, acc;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear_grid();
        step();
        fire(12'hF00, 4'd1, cyc);      // slot0
        fire(12'h0F0, 4'd2, cyc);      // slot1
        fire(12'h00F, 4'd1, cyc);      // slot2 overlaps slot0's path
        acc = 0;
        repeat (3) begin do_sweep(h); acc += h; end
        total++; if (acc !== 0 || bulletBillXLoc[0] !== 4'd5 || bulletBillXLoc[2] !== 4'd5) begin bad++;
            $display("FAIL b2b_setup got=hits%0d x0=%0d x2=%0d want=0,5,5", acc, bulletBillXLoc[0], bulletBillXLoc[2]); end
        ddavers[0][1] = 12'hF00;
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        step();
        total++; if (hit_valid !== 1'b1 || hit_kill !== 1'b1 || hit_row !== 3'd0 || hit_col !== 3'd1) begin bad++;
            $display("FAIL b2b_kill got=hv%b k%b r%0d c%0d want=hv1 k1 r0 c1", hit_valid, hit_kill, hit_row, hit_col); end
        move_tick = 1'b1;              // arrives in CHECK1, must be dropped
        step();
        move_tick = 1'b0;
        total++; if (hit_valid !== 1'b0 || bulletBillXLoc[1] !== 4'd6 || bulletBillXLoc[2] !== 4'd6) begin bad++;
            $display("FAIL b2b_e2 got=hv%b x1=%0d x2=%0d want=hv0 6 6", hit_valid, bulletBillXLoc[1], bulletBillXLoc[2]); end
        step();
        total++; if (hit_valid !== 1'b0 || bulletBillColor[2] !== 12'h00F || busy !== 1'b0) begin bad++;
            $display("FAIL b2b_survive got=hv%b c2=%h busy%b want=hv0 00F busy0", hit_valid, bulletBillColor[2], busy); end
        step();
        total++; if (busy !== 1'b0 || bulletBillXLoc[2] !== 4'd6) begin bad++;
            $display("FAIL b2b_no_queue got=busy%b x2=%0d want=busy0 6", busy, bulletBillXLoc[2]); end
        // Reset in CHECK1 with a hit pending for slot2 in CHECK2
        do_sweep(h);
        ddavers[0][2] = 12'h00F;
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        total++; if (bulletBillXLoc[2] !== 4'd8) begin bad++;
            $display("FAIL rst_setup got=x2=%0d want=8", bulletBillXLoc[2]); end
        step();
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || bulletBillColor[2] !== 12'h0 || hit_valid !== 1'b0) begin bad++;
            $display("FAIL rst_mid got=busy%b c2=%h hv%b want=0 000 0", busy, bulletBillColor[2], hit_valid); end
        step();
        rst_n = 1'b1;
        acc = 0;
        repeat (4) begin step(); acc += int'(hit_valid); end
        total++; if (acc !== 0 || busy !== 1'b0) begin bad++;
            $display("FAIL rst_no_hit got=hits%0d busy%b want=0 0", acc, busy); end
        $display("reset mid-sweep done");
    endtask

    initial begin
        rst_n      = 1'b0;
        move_tick  = 1'b0;
        fire_req   = 1'b0;
        fire_color = 12'h000;
        blockieee  = 4'd0;
        clear_grid();
        test_reset();
        test_fire();
        test_hit_kill();
        test_hit_nokill();
        test_exit();
        test_full();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
